// File: rtl/disp_page_scheduler.sv
// Chooses which 16-bit half of four 32-bit debug sources feeds the 7-segment scanner:
// debounced button stepping, timed auto rotation, or urgent preemption by a source.
module disp_page_scheduler #(
   parameter int unsigned DWELL   = 25_000_000,
   parameter int unsigned DEB_CYC = 500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] src0,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [31:0] src3,
   input  logic        btn_next,
   input  logic        auto_en,
   input  logic [3:0]  urg_req,
   output logic [3:0]  urg_ack,
   output logic [2:0]  page,
   output logic [1:0]  mode,
   output logic [15:0] disp_word
);

   localparam int DW  = $clog2(DWELL);
   localparam int DBW = $clog2(DEB_CYC);
   localparam logic [DW-1:0]  DWELL_TC = DW'(DWELL - 1);
   localparam logic [DW-1:0]  DWELL_1  = DW'(1);
   localparam logic [DBW-1:0] DEB_TC   = DBW'(DEB_CYC - 1);
   localparam logic [DBW-1:0] DEB_1    = DBW'(1);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_AUTO   = 2'b01,
      ST_URGENT = 2'b10
   } state_t;

   state_t         state;
   logic           btn_s1;
   logic           btn_s2;
   logic           btn_acc;
   logic           press;
   logic [DBW-1:0] deb_cnt;
   logic [DW-1:0]  dwell_cnt;
   logic [DW-1:0]  hold_cnt;
   logic [2:0]     saved_page;
   logic [1:0]     urg_idx;
   logic [31:0]    src_sel;

   function automatic logic [1:0] lowest_req(input logic [3:0] req);
      if (req[0])      return 2'd0;
      else if (req[1]) return 2'd1;
      else if (req[2]) return 2'd2;
      else             return 2'd3;
   endfunction

   // The accepted level only flips after DEB_CYC consecutive disagreeing cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         btn_acc <= 1'b0;
         deb_cnt <= '0;
         press   <= 1'b0;
      end else begin
         btn_s1 <= btn_next;
         btn_s2 <= btn_s1;
         press  <= 1'b0;
         if (btn_s2 != btn_acc) begin
            if (deb_cnt == DEB_TC) begin
               btn_acc <= btn_s2;
               deb_cnt <= '0;
               press   <= btn_s2;
            end else begin
               deb_cnt <= deb_cnt + DEB_1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_MANUAL;
         page       <= '0;
         saved_page <= '0;
         urg_idx    <= '0;
         dwell_cnt  <= '0;
         hold_cnt   <= '0;
         urg_ack    <= '0;
      end else begin
         urg_ack <= '0;
         case (state)
            ST_MANUAL, ST_AUTO: begin
               if (|urg_req) begin
                  urg_idx    <= lowest_req(urg_req);
                  saved_page <= page;
                  page       <= {lowest_req(urg_req), 1'b0};
                  urg_ack    <= 4'b0001 << lowest_req(urg_req);
                  hold_cnt   <= '0;
                  dwell_cnt  <= '0;
                  state      <= ST_URGENT;
               end else if (press) begin
                  page      <= page + 3'd1;
                  dwell_cnt <= '0;
               end else if (state == ST_AUTO && dwell_cnt == DWELL_TC) begin
                  page      <= page + 3'd1;
                  dwell_cnt <= '0;
               end else if (state == ST_AUTO && !auto_en) begin
                  state <= ST_MANUAL;
               end else if (state == ST_MANUAL && auto_en) begin
                  state     <= ST_AUTO;
                  dwell_cnt <= '0;
               end else if (state == ST_AUTO) begin
                  dwell_cnt <= dwell_cnt + DWELL_1;
               end
            end
            ST_URGENT: begin
               if (!urg_req[urg_idx] && hold_cnt == DWELL_TC) begin
                  dwell_cnt <= '0;
                  if (|urg_req) begin
                     // Chain straight into the next urgent source; saved_page stays the pre-urgent page.
                     urg_idx  <= lowest_req(urg_req);
                     page     <= {lowest_req(urg_req), 1'b0};
                     urg_ack  <= 4'b0001 << lowest_req(urg_req);
                     hold_cnt <= '0;
                  end else begin
                     page  <= saved_page;
                     state <= auto_en ? ST_AUTO : ST_MANUAL;
                  end
               end else begin
                  if (hold_cnt != DWELL_TC) hold_cnt <= hold_cnt + DWELL_1;
                  if (dwell_cnt == DWELL_TC) begin
                     page[0]   <= ~page[0];
                     dwell_cnt <= '0;
                  end else begin
                     dwell_cnt <= dwell_cnt + DWELL_1;
                  end
               end
            end
            default: state <= ST_MANUAL;
         endcase
      end
   end

   assign mode = state;

   always_comb begin
      case (page[2:1])
         2'd0:    src_sel = src0;
         2'd1:    src_sel = src1;
         2'd2:    src_sel = src2;
         default: src_sel = src3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) disp_word <= '0;
      else     disp_word <= page[0] ? src_sel[31:16] : src_sel[15:0];
   end

endmodule

// File: tb/tb_disp_page_scheduler.sv
// Bench for disp_page_scheduler with short timing (DWELL=8, DEB_CYC=4): button stepping,
// bounce rejection, auto rotation, urgent preemption/chaining and asynchronous reset.
module tb_disp_page_scheduler;

   localparam int DWELL   = 8;
   localparam int DEB_CYC = 4;
   localparam logic [1:0] M_MAN  = 2'b00;
   localparam logic [1:0] M_AUTO = 2'b01;
   localparam logic [1:0] M_URG  = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] src0, src1, src2, src3;
   logic        btn_next;
   logic        auto_en;
   logic [3:0]  urg_req;
   logic [3:0]  urg_ack;
   logic [2:0]  page;
   logic [1:0]  mode;
   logic [15:0] disp_word;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  exp_q[$];
   int          exp_t[$];
   logic [2:0]  page_log[$];
   logic [15:0] word_log[$];
   logic [1:0]  mode_log[$];
   int          chg_t[$];
   logic [2:0]  chg_p[$];

   disp_page_scheduler #(.DWELL(DWELL), .DEB_CYC(DEB_CYC)) dut (
      .clk(clk), .rst(rst),
      .src0(src0), .src1(src1), .src2(src2), .src3(src3),
      .btn_next(btn_next), .auto_en(auto_en), .urg_req(urg_req),
      .urg_ack(urg_ack), .page(page), .mode(mode), .disp_word(disp_word)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog got=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // driver: one button level per cycle from pat, outputs logged at every falling edge
   task automatic run(input int len, input logic [63:0] pat);
      page_log.delete(); word_log.delete(); mode_log.delete();
      page_log.push_back(page); word_log.push_back(disp_word); mode_log.push_back(mode);
      for (int i = 0; i < len; i++) begin
         btn_next = (i < 64) ? pat[i] : 1'b0;
         @(negedge clk);
         page_log.push_back(page); word_log.push_back(disp_word); mode_log.push_back(mode);
      end
      btn_next = 1'b0;
   endtask

   task automatic find_changes();
      chg_t.delete(); chg_p.delete();
      for (int i = 1; i < page_log.size(); i++)
         if (page_log[i] !== page_log[i-1]) begin
            chg_t.push_back(i);
            chg_p.push_back(page_log[i]);
         end
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_next = 1'b0; auto_en = 1'b0; urg_req = 4'b0;
      src0 = 32'hDEAD_BEEF; src1 = 32'h1234_ABCD; src2 = 32'hCAFE_F00D; src3 = 32'h5A5A_0F0F;
      repeat (3) @(negedge clk);
      checks++; if (page !== 3'd0) begin failures++; $display("FAIL reset_page got=%0d required=0", page); end
      checks++; if (disp_word !== 16'h0) begin failures++; $display("FAIL reset_word got=%h required=0000", disp_word); end
      checks++; if (urg_ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b required=0000", urg_ack); end
      checks++; if (mode !== M_MAN) begin failures++; $display("FAIL reset_mode got=%b required=00", mode); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (disp_word !== 16'hBEEF) begin failures++; $display("FAIL reset_first_word got=%h required=beef", disp_word); end
   endtask

   task automatic test_manual();
      logic [15:0] old_w[3];
      logic [15:0] new_w[3];
      logic [2:0]  e;
      int          t;
      old_w[0] = 16'hBEEF; old_w[1] = 16'hDEAD; old_w[2] = 16'hABCD;
      new_w[0] = 16'hDEAD; new_w[1] = 16'hABCD; new_w[2] = 16'h1234;
      for (int n = 1; n <= 3; n++) begin
         exp_q.push_back(3'(n));
         run(20, 64'hFF);
         find_changes();
         for (int k = 0; k < chg_p.size(); k++) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL manual_extra got page=%0d required=none", chg_p[k]);
            end else begin
               e = exp_q.pop_front();
               if (chg_p[k] !== e) begin failures++; $display("FAIL manual_page got=%0d required=%0d", chg_p[k], e); end
            end
         end
         checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL manual_missing got pending=%0d required=0", exp_q.size()); end
         exp_q.delete();
         if (chg_t.size() > 0) begin
            t = chg_t[0];
            checks++;
            if (word_log[t] !== old_w[n-1]) begin failures++; $display("FAIL manual_word_latency got=%h required=%h", word_log[t], old_w[n-1]); end
            if (t + 1 < word_log.size()) begin
               checks++;
               if (word_log[t+1] !== new_w[n-1]) begin failures++; $display("FAIL manual_word got=%h required=%h", word_log[t+1], new_w[n-1]); end
            end
         end
      end
   endtask

   task automatic test_bounce();
      logic [2:0] e;
      exp_q.push_back(3'd4);
      run(40, 64'h0BF5);
      find_changes();
      for (int k = 0; k < chg_p.size(); k++) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++; $display("FAIL bounce_extra got page=%0d required=none", chg_p[k]);
         end else begin
            e = exp_q.pop_front();
            if (chg_p[k] !== e) begin failures++; $display("FAIL bounce_page got=%0d required=%0d", chg_p[k], e); end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bounce_missing got pending=%0d required=0", exp_q.size()); end
      exp_q.delete();
      checks++; if (word_log[39] !== 16'hF00D) begin failures++; $display("FAIL bounce_word got=%h required=f00d", word_log[39]); end
      run(12, 64'h0);
      find_changes();
      checks++; if (chg_t.size() != 0) begin failures++; $display("FAIL bounce_release got changes=%0d required=0", chg_t.size()); end
   endtask

   task automatic test_auto();
      logic [2:0] e;
      int         et;
      for (int n = 5; n <= 7; n++) begin
         exp_q.push_back(3'(n));
         run(20, 64'hFF);
         find_changes();
         for (int k = 0; k < chg_p.size(); k++) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL auto_setup_extra got page=%0d required=none", chg_p[k]);
            end else begin
               e = exp_q.pop_front();
               if (chg_p[k] !== e) begin failures++; $display("FAIL auto_setup_page got=%0d required=%0d", chg_p[k], e); end
            end
         end
         exp_q.delete();
      end
      // auto entry at cycle 1, first rotation 8 cycles later
      auto_en = 1'b1;
      exp_q.push_back(3'd0); exp_t.push_back(9);
      exp_q.push_back(3'd1); exp_t.push_back(17);
      run(17, 64'h0);
      checks++; if (mode_log[1] !== M_AUTO) begin failures++; $display("FAIL auto_mode got=%b required=01", mode_log[1]); end
      find_changes();
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < chg_p.size(); k++) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL auto_extra got page=%0d at=%0d required=none", chg_p[k], chg_t[k]);
            end else begin
               e = exp_q.pop_front(); et = exp_t.pop_front();
               if (chg_p[k] !== e || chg_t[k] != et)
                  begin failures++; $display("FAIL auto_step got page=%0d at=%0d required page=%0d at=%0d", chg_p[k], chg_t[k], e, et); end
            end
         end
         checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL auto_missing got pending=%0d required=0", exp_q.size()); end
         exp_q.delete(); exp_t.delete();
         if (pass == 0) begin
            // press mid-dwell: immediate step, rotation restarts its full dwell
            exp_q.push_back(3'd2); exp_t.push_back(7);
            exp_q.push_back(3'd3); exp_t.push_back(15);
            exp_q.push_back(3'd4); exp_t.push_back(23);
            run(30, 64'hFF);
            find_changes();
         end
      end
   endtask

   task automatic test_urgent();
      @(negedge clk);
      checks++; if (page !== 3'd5 || mode !== M_AUTO) begin failures++; $display("FAIL urg_start got page=%0d mode=%b required page=5 mode=01", page, mode); end
      urg_req = 4'b0110;
      @(negedge clk);
      checks++; if (urg_ack !== 4'b0010) begin failures++; $display("FAIL urg_ack1 got=%b required=0010", urg_ack); end
      checks++; if (page !== 3'd2 || mode !== M_URG) begin failures++; $display("FAIL urg_enter got page=%0d mode=%b required page=2 mode=10", page, mode); end
      @(negedge clk);
      checks++; if (urg_ack !== 4'b0) begin failures++; $display("FAIL urg_ack_pulse got=%b required=0000", urg_ack); end
      checks++; if (disp_word !== 16'hABCD) begin failures++; $display("FAIL urg_word got=%h required=abcd", disp_word); end
      repeat (6) @(negedge clk);
      checks++; if (page !== 3'd2) begin failures++; $display("FAIL urg_hold_lo got page=%0d required=2", page); end
      @(negedge clk);
      checks++; if (page !== 3'd3) begin failures++; $display("FAIL urg_toggle got page=%0d required=3", page); end
      urg_req = 4'b0000;
      @(negedge clk);
      checks++; if (page !== 3'd5 || mode !== M_AUTO) begin failures++; $display("FAIL urg_exit got page=%0d mode=%b required page=5 mode=01", page, mode); end
      @(negedge clk);
      checks++; if (disp_word !== 16'hCAFE) begin failures++; $display("FAIL urg_exit_word got=%h required=cafe", disp_word); end
      // chained: source 2 stays requested when source 1 lets go
      urg_req = 4'b0110;
      @(negedge clk);
      checks++; if (urg_ack !== 4'b0010 || page !== 3'd2) begin failures++; $display("FAIL chain_enter got ack=%b page=%0d required ack=0010 page=2", urg_ack, page); end
      repeat (3) @(negedge clk);
      urg_req = 4'b0100;
      repeat (4) @(negedge clk);
      checks++; if (page !== 3'd2 || mode !== M_URG) begin failures++; $display("FAIL chain_min_hold got page=%0d mode=%b required page=2 mode=10", page, mode); end
      @(negedge clk);
      checks++; if (page !== 3'd4 || urg_ack !== 4'b0100 || mode !== M_URG)
         begin failures++; $display("FAIL chain_next got page=%0d ack=%b mode=%b required page=4 ack=0100 mode=10", page, urg_ack, mode); end
      urg_req = 4'b0000;
      repeat (7) @(negedge clk);
      checks++; if (page !== 3'd4) begin failures++; $display("FAIL chain_hold got page=%0d required=4", page); end
      @(negedge clk);
      checks++; if (page !== 3'd5 || mode !== M_AUTO) begin failures++; $display("FAIL chain_exit got page=%0d mode=%b required page=5 mode=01", page, mode); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ack_seen;
      auto_en = 1'b0;
      urg_req = 4'b1000;
      @(negedge clk);
      checks++; if (urg_ack !== 4'b1000 || page !== 3'd6) begin failures++; $display("FAIL rmid_grant got ack=%b page=%0d required ack=1000 page=6", urg_ack, page); end
      rst = 1'b1;
      #1;
      checks++; if (page !== 3'd0 || disp_word !== 16'h0 || urg_ack !== 4'b0 || mode !== M_MAN)
         begin failures++; $display("FAIL rmid_urgent got page=%0d word=%h ack=%b mode=%b required 0/0000/0000/00", page, disp_word, urg_ack, mode); end
      urg_req = 4'b0000;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      ack_seen = 4'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ack_seen |= urg_ack;
      end
      checks++; if (ack_seen !== 4'b0 || page !== 3'd0) begin failures++; $display("FAIL rmid_no_regrant got ack=%b page=%0d required ack=0000 page=0", ack_seen, page); end
      run(20, 64'hFF);
      checks++; if (page !== 3'd1) begin failures++; $display("FAIL rmid_setup got page=%0d required=1", page); end
      btn_next = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (page !== 3'd0 || disp_word !== 16'h0) begin failures++; $display("FAIL rmid_press got page=%0d word=%h required page=0 word=0000", page, disp_word); end
      btn_next = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      run(20, 64'h0);
      find_changes();
      checks++; if (chg_t.size() != 0 || page !== 3'd0) begin failures++; $display("FAIL rmid_lost_press got changes=%0d page=%0d required 0/0", chg_t.size(), page); end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_bounce();
      test_auto();
      test_urgent();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
